// File: rtl/bf_pkg.sv
// Shared types and constants for the edge_fetch graph-image reader.
package bf_pkg;

  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MAX_EDGES = 2730;
  localparam int unsigned CNT_W     = 12;

  // Image layout: two header bytes, then three bytes per edge record
  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned REC_BYTES = 3;
  localparam int unsigned OFF_SRC   = 0;
  localparam int unsigned OFF_DST   = 1;
  localparam int unsigned OFF_WT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_RD_SRC,
    ST_RD_DST,
    ST_RD_WT,
    ST_PRESENT,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] weight;
    logic       last;
  } edge_rec_t;

endpackage

// File: rtl/edge_fetch_if.sv
// Control, SRAM read port and edge stream of edge_fetch bundled together.
interface edge_fetch_if #(
  parameter int unsigned ADDR_W = bf_pkg::ADDR_W,
  parameter int unsigned DATA_W = bf_pkg::DATA_W
) ();

  logic                start;
  logic [ADDR_W-1:0]   ReadAddress;
  logic [DATA_W-1:0]   ReadBus;
  logic                edge_valid;
  logic                edge_ready;
  logic [7:0]          edge_src;
  logic [7:0]          edge_dst;
  logic signed [7:0]   edge_weight;
  logic                edge_last;
  logic                busy;
  logic                done;
  logic                error;

  modport master (
    input  start, ReadBus, edge_ready,
    output ReadAddress, edge_valid, edge_src, edge_dst, edge_weight,
           edge_last, busy, done, error
  );

  modport slave (
    output start, ReadBus, edge_ready,
    input  ReadAddress, edge_valid, edge_src, edge_dst, edge_weight,
           edge_last, busy, done, error
  );

endinterface

// File: rtl/edge_fetch.sv
// Walks a graph image in SRAM one byte per cycle and streams its edges
// out over a valid/ready handshake.
module edge_fetch #(
  parameter int unsigned ADDR_W    = bf_pkg::ADDR_W,
  parameter int unsigned DATA_W    = bf_pkg::DATA_W,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_EDGES = bf_pkg::MAX_EDGES
) (
  input  logic        clock,
  input  logic        reset,
  edge_fetch_if.master bus
);

  import bf_pkg::*;

  localparam logic [ADDR_W-1:0] W_BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] W_FIRST  = ADDR_W'(BASE_ADDR + HDR_BYTES + OFF_SRC);
  localparam logic [15:0]       W_MAX    = 16'(MAX_EDGES);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_cnt_hi;
  logic [CNT_W-1:0]  r_remain;
  edge_rec_t         r_edge;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic [DATA_W-1:0] w_rd;
  logic [7:0]        w_byte;
  logic [15:0]       w_count;
  logic              w_last_rec;

  assign w_rd       = bus.ReadBus;
  assign w_byte     = w_rd[7:0];
  assign w_count    = {r_cnt_hi, w_byte};
  assign w_last_rec = (r_remain == CNT_W'(1));

  // Single-process FSM; every output is a register written here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= W_BASE;
      r_cnt_hi <= '0;
      r_remain <= '0;
      r_edge   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_addr <= W_BASE;
          if (bus.start) begin
            r_state <= ST_HDR_HI;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
          end
        end
        ST_HDR_HI: begin
          r_cnt_hi <= w_byte;
          r_addr   <= W_BASE + ADDR_W'(1);
          r_state  <= ST_HDR_LO;
        end
        ST_HDR_LO: begin
          r_remain <= CNT_W'(w_count);
          if (w_count == 16'd0) begin
            r_addr  <= W_BASE;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else if (w_count > W_MAX) begin
            r_addr  <= W_BASE;
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_addr  <= W_FIRST;
            r_state <= ST_RD_SRC;
          end
        end
        ST_RD_SRC: begin
          r_edge.src <= w_byte;
          r_addr     <= r_addr + ADDR_W'(1);
          r_state    <= ST_RD_DST;
        end
        ST_RD_DST: begin
          r_edge.dst <= w_byte;
          r_addr     <= r_addr + ADDR_W'(1);
          r_state    <= ST_RD_WT;
        end
        ST_RD_WT: begin
          r_edge.weight <= w_byte;
          r_edge.last   <= w_last_rec;
          // Park on BASE_ADDR after the final record so the pointer never wraps
          r_addr        <= w_last_rec ? W_BASE : r_addr + ADDR_W'(1);
          r_valid       <= 1'b1;
          r_state       <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (bus.edge_ready) begin
            r_valid     <= 1'b0;
            r_edge.last <= 1'b0;
            r_remain    <= r_remain - CNT_W'(1);
            if (r_edge.last) begin
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_state <= ST_RD_SRC;
            end
          end
        end
        ST_FINISH: begin
          r_addr  <= W_BASE;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ReadAddress = r_addr;
  assign bus.edge_valid  = r_valid;
  assign bus.edge_src    = r_edge.src;
  assign bus.edge_dst    = r_edge.dst;
  assign bus.edge_weight = r_edge.weight;
  assign bus.edge_last   = r_edge.last;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_edge_fetch.sv
// Self-checking bench for edge_fetch: SRAM image model plus cycle-level
// expectations derived from the image layout and handshake timing rules.
module tb_edge_fetch;

  import bf_pkg::*;

  localparam int BASE = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  edge_fetch_if u_if ();

  edge_fetch #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BASE_ADDR(BASE),
    .MAX_EDGES(MAX_EDGES)
  ) u_dut (
    .clock(clk),
    .reset(rst),
    .bus  (u_if)
  );

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  assign u_if.ReadBus = mem[u_if.ReadAddress];

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  function automatic logic [ADDR_W-1:0] a(input int x);
    return ADDR_W'(x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic load_image(input int count);
    mem[a(BASE)]   = 8'(count >> 8);
    mem[a(BASE+1)] = 8'(count);
    if (count <= int'(MAX_EDGES))
      for (int i = 0; i < count * int'(REC_BYTES); i++)
        mem[a(BASE + int'(HDR_BYTES) + i)] = 8'($urandom);
  endtask

  function automatic int rec_addr(input int k, input int off);
    return BASE + int'(HDR_BYTES) + int'(REC_BYTES) * k + off;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(u_if.edge_valid), 32'd0);
    chk({tag, "_last"},  32'(u_if.edge_last),  32'd0);
    chk({tag, "_busy"},  32'(u_if.busy),       32'd0);
    chk({tag, "_done"},  32'(u_if.done),       32'd0);
    chk({tag, "_error"}, 32'(u_if.error),      32'd0);
    chk({tag, "_src"},   32'(u_if.edge_src),   32'd0);
    chk({tag, "_dst"},   32'(u_if.edge_dst),   32'd0);
    chk({tag, "_wt"},    32'($unsigned(u_if.edge_weight)), 32'd0);
    chk({tag, "_addr"},  32'(u_if.ReadAddress), 32'(BASE));
  endtask

  // Called at a falling edge; that cycle carries the start pulse (cycle 0).
  task automatic run_fetch(input int stall_edge, input int stall_len,
                           input bit rnd_ready, input bit extra_start);
    int  count, n_edges, c, e, nv, dc, stalled, limit;
    bit  oversize, exp_valid, rdy;
    count    = int'({mem[a(BASE)], mem[a(BASE+1)]});
    oversize = (count > int'(MAX_EDGES));
    n_edges  = oversize ? 0 : count;
    dc       = (n_edges == 0) ? 3 : -1;
    nv       = 6;
    e        = 0;
    stalled  = 0;
    limit    = 50 + n_edges * 40;
    u_if.start      = 1'b1;
    u_if.edge_ready = 1'b1;
    c = 1;
    while (c <= limit) begin
      @(negedge clk);
      u_if.start = 1'b0;
      exp_valid  = (e < n_edges) && (c >= nv);
      chk("valid", 32'(u_if.edge_valid), 32'(exp_valid));
      chk("done",  32'(u_if.done),       32'(c == dc));
      chk("error", 32'(u_if.error),      32'(oversize && c >= 3));
      if (dc < 0 || c < dc) chk("busy", 32'(u_if.busy), 32'd1);
      if (c <= 2) chk("addr_hdr", 32'(u_if.ReadAddress), 32'(BASE + c - 1));
      if (e < n_edges && c == nv - 3)
        chk("addr_src", 32'(u_if.ReadAddress), 32'(rec_addr(e, int'(OFF_SRC))));
      if (exp_valid) begin
        chk("src",  32'(u_if.edge_src), 32'(mem[a(rec_addr(e, int'(OFF_SRC)))]));
        chk("dst",  32'(u_if.edge_dst), 32'(mem[a(rec_addr(e, int'(OFF_DST)))]));
        chk("wt",   32'(int'(u_if.edge_weight)),
                    32'(int'($signed(mem[a(rec_addr(e, int'(OFF_WT)))]))));
        chk("last", 32'(u_if.edge_last), 32'(e == n_edges - 1));
      end
      if (c == dc) break;
      if (rnd_ready) rdy = ($urandom_range(0, 2) != 0);
      else           rdy = !(exp_valid && e == stall_edge && stalled < stall_len);
      if (exp_valid && !rdy) stalled++;
      u_if.edge_ready = rdy;
      if (extra_start && exp_valid) u_if.start = 1'b1;
      if (exp_valid && rdy) begin
        e++;
        nv = c + 4;
        if (e == n_edges) dc = c + 1;
      end
      c++;
    end
    chk("reach_done", 32'(c), 32'(dc));
    @(negedge clk);
    u_if.edge_ready = 1'b1;
    chk("post_done",  32'(u_if.done),        32'd0);
    chk("post_busy",  32'(u_if.busy),        32'd0);
    chk("post_valid", 32'(u_if.edge_valid),  32'd0);
    chk("post_last",  32'(u_if.edge_last),   32'd0);
    chk("post_addr",  32'(u_if.ReadAddress), 32'(BASE));
    chk("post_error", 32'(u_if.error),       32'(oversize));
  endtask

  initial begin
    u_if.start      = 1'b0;
    u_if.edge_ready = 1'b1;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);

    @(negedge clk);
    #1;
    check_all_zero("rst");

    // Single edge; start shares the slot with reset release
    @(negedge clk);
    mem[a(BASE)]   = 8'h00;
    mem[a(BASE+1)] = 8'h01;
    mem[a(BASE+2)] = 8'h03;
    mem[a(BASE+3)] = 8'h05;
    mem[a(BASE+4)] = 8'hFA;
    rst = 1'b0;
    run_fetch(-1, 0, 1'b0, 1'b0);

    // Zero edges
    load_image(0);
    run_fetch(-1, 0, 1'b0, 1'b0);

    // Backpressure on edge 1
    load_image(3);
    run_fetch(1, 5, 1'b0, 1'b0);

    // Oversize header 0x0AAB
    load_image(2731);
    run_fetch(-1, 0, 1'b0, 1'b0);

    // Error clears on the next start
    load_image(2);
    run_fetch(-1, 0, 1'b0, 1'b0);

    // Reset during RD_DST of edge 0, then replay
    load_image(3);
    u_if.start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      u_if.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_fetch(-1, 0, 1'b0, 1'b0);

    // Start pulses while presenting are ignored
    load_image(3);
    run_fetch(-1, 0, 1'b0, 1'b1);

    // Randomized images with random consumer readiness
    for (int i = 0; i < 6; i++) begin
      load_image(int'($urandom_range(1, 8)));
      run_fetch(-1, 0, 1'b1, 1'(i % 2));
    end
    for (int i = 0; i < 2; i++) begin
      load_image(int'($urandom_range(MAX_EDGES + 1, 65535)));
      run_fetch(-1, 0, 1'b0, 1'b0);
    end

    // Largest legal image reaches the top of the address space
    load_image(int'(MAX_EDGES));
    run_fetch(-1, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
